routing_lookup_arbiter: RTL and testbench

- Shares the two lookup ports (A and B) of routing_system_top among NUM_REQ client requesters.
- Each cycle it grants up to two requests in round-robin order, drives them onto req_a_* and req_b_*, and tracks each issued lookup through the fixed-latency pipeline.
- When the matching resp_*_valid arrives, it reports which client the response belongs to.
- Sits between client engines (packet builders, QP managers) and routing_system_top.

---
 rtl/routing_pkg.sv | 18 +
 rtl/lookup_tag_pipe.sv | 48 ++++
 rtl/routing_lookup_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_routing_lookup_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/routing_pkg.sv
// Shared definitions for the routing lookup path: the two lookup type codes,
// the lookup field widths, and the request bundle sent to the routing system.
package routing_pkg;

   localparam logic LK_HOST    = 1'b0;
   localparam logic LK_PATH    = 1'b1;

   localparam int   HOST_IDX_W = 6;
   localparam int   SW_ID_W    = 4;

   typedef struct packed {
      logic                  lk_type;
      logic [HOST_IDX_W-1:0] host_idx;
      logic [SW_ID_W-1:0]    src_sw;
      logic [SW_ID_W-1:0]    dst_sw;
   } lookup_req_t;

endpackage

// File: rtl/lookup_tag_pipe.sv
// Tracks lookups issued on one routing-system port. Each issued request
// pushes {v, id} into a LATENCY-deep shift register; the last stage lines up
// with the cycle the routing system returns that lookup's response.
//   in_v / in_id      : request strobe and owning client id
//   slot_v / slot_id  : tag expected to match this cycle's response
//   any_v             : some tracked lookup is still in flight
module lookup_tag_pipe #(
   parameter int LATENCY = 3,
   parameter int ID_W    = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_v,
   input  logic [ID_W-1:0] in_id,
   output logic            slot_v,
   output logic [ID_W-1:0] slot_id,
   output logic            any_v
);

   logic [LATENCY-1:0]           v_q, v_d;
   logic [LATENCY-1:0][ID_W-1:0] id_q, id_d;

   always_comb begin
      v_d     = v_q;
      id_d    = id_q;
      v_d[0]  = in_v;
      id_d[0] = in_id;
      for (int k = 1; k < LATENCY; k++) begin
         v_d[k]  = v_q[k-1];
         id_d[k] = id_q[k-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q  <= '0;
         id_q <= '0;
      end else begin
         v_q  <= v_d;
         id_q <= id_d;
      end
   end

   assign slot_v  = v_q[LATENCY-1];
   assign slot_id = id_q[LATENCY-1];
   assign any_v   = |v_q;

endmodule

// File: rtl/routing_lookup_arbiter.sv
// Shares the two lookup ports (A, B) of the routing system among NUM_REQ
// clients. Up to two round-robin grants per cycle, registered issue onto
// req_a_* / req_b_*, and per-port tag tracking so each response is reported
// with its owning client id.
//   cli_*        : client requests (fields packed per client), cli_ready accept
//   req_a/b_*    : registered lookup strobes and fields to the routing system
//   resp_a/b_*   : response strobes back from the routing system
//   done_a/b_*   : response matched a tracked lookup, with its client id
//   lat_err      : sticky response/tag mismatch, cleared by err_clr
//   busy         : lookups in flight or a request being issued
module routing_lookup_arbiter
   import routing_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int LATENCY = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          system_ready,
   input  logic [NUM_REQ-1:0]            cli_valid,
   output logic [NUM_REQ-1:0]            cli_ready,
   input  logic [NUM_REQ-1:0]            cli_type,
   input  logic [NUM_REQ*HOST_IDX_W-1:0] cli_host_idx,
   input  logic [NUM_REQ*SW_ID_W-1:0]    cli_src_sw,
   input  logic [NUM_REQ*SW_ID_W-1:0]    cli_dst_sw,
   output logic                          req_a_valid,
   output logic                          req_a_type,
   output logic [HOST_IDX_W-1:0]         req_a_host_idx,
   output logic [SW_ID_W-1:0]            req_a_src_sw,
   output logic [SW_ID_W-1:0]            req_a_dst_sw,
   output logic                          req_b_valid,
   output logic                          req_b_type,
   output logic [HOST_IDX_W-1:0]         req_b_host_idx,
   output logic [SW_ID_W-1:0]            req_b_src_sw,
   output logic [SW_ID_W-1:0]            req_b_dst_sw,
   input  logic                          resp_a_valid,
   input  logic                          resp_b_valid,
   output logic                          done_a_valid,
   output logic [ID_W-1:0]               done_a_id,
   output logic                          done_b_valid,
   output logic [ID_W-1:0]               done_b_id,
   output logic                          lat_err,
   input  logic                          err_clr,
   output logic                          busy
);

   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic            req_a_valid_q, req_a_valid_d;
   logic            req_b_valid_q, req_b_valid_d;
   lookup_req_t     req_a_q, req_a_d;
   lookup_req_t     req_b_q, req_b_d;
   logic [ID_W-1:0] id_a_q, id_a_d;
   logic [ID_W-1:0] id_b_q, id_b_d;
   logic            lat_err_q, lat_err_d;

   logic            grant_a, grant_b;
   logic [ID_W-1:0] idx_a, idx_b, scan_idx;
   logic            slot_a_v, slot_b_v, any_a, any_b;
   logic [ID_W-1:0] slot_a_id, slot_b_id;
   logic            err_a, err_b;

   function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx);
      return (int'(idx) == NUM_REQ - 1) ? '0 : idx + ID_W'(1);
   endfunction

   // First valid client from rr_ptr wins port A, the next one port B. The
   // scan visits each client once, so a client can never take both ports.
   always_comb begin
      grant_a  = 1'b0;
      grant_b  = 1'b0;
      idx_a    = '0;
      idx_b    = '0;
      scan_idx = '0;
      if (system_ready && !rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (cli_valid[scan_idx]) begin
               if (!grant_a) begin
                  grant_a = 1'b1;
                  idx_a   = scan_idx;
               end else if (!grant_b) begin
                  grant_b = 1'b1;
                  idx_b   = scan_idx;
               end
            end
         end
      end
   end

   always_comb begin
      cli_ready = '0;
      if (grant_a) cli_ready[idx_a] = 1'b1;
      if (grant_b) cli_ready[idx_b] = 1'b1;
   end

   // A response and its expected tag must coincide; either without the
   // other is flagged and the tag simply falls off the end of the pipe.
   assign err_a = slot_a_v ^ resp_a_valid;
   assign err_b = slot_b_v ^ resp_b_valid;

   always_comb begin
      req_a_valid_d = grant_a;
      req_b_valid_d = grant_b;
      req_a_d       = req_a_q;
      req_b_d       = req_b_q;
      id_a_d        = id_a_q;
      id_b_d        = id_b_q;
      rr_ptr_d      = rr_ptr_q;
      if (grant_a) begin
         req_a_d.lk_type  = cli_type[idx_a];
         req_a_d.host_idx = cli_host_idx[idx_a*HOST_IDX_W +: HOST_IDX_W];
         req_a_d.src_sw   = cli_src_sw[idx_a*SW_ID_W +: SW_ID_W];
         req_a_d.dst_sw   = cli_dst_sw[idx_a*SW_ID_W +: SW_ID_W];
         id_a_d           = idx_a;
         rr_ptr_d         = next_ptr(idx_a);
      end
      // B is always later in scan order than A, so it sets the pointer.
      if (grant_b) begin
         req_b_d.lk_type  = cli_type[idx_b];
         req_b_d.host_idx = cli_host_idx[idx_b*HOST_IDX_W +: HOST_IDX_W];
         req_b_d.src_sw   = cli_src_sw[idx_b*SW_ID_W +: SW_ID_W];
         req_b_d.dst_sw   = cli_dst_sw[idx_b*SW_ID_W +: SW_ID_W];
         id_b_d           = idx_b;
         rr_ptr_d         = next_ptr(idx_b);
      end
      // Set has priority over a same-cycle clear.
      lat_err_d = (lat_err_q && !err_clr) || err_a || err_b;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q      <= '0;
         req_a_valid_q <= 1'b0;
         req_b_valid_q <= 1'b0;
         req_a_q       <= '0;
         req_b_q       <= '0;
         id_a_q        <= '0;
         id_b_q        <= '0;
         lat_err_q     <= 1'b0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         req_a_valid_q <= req_a_valid_d;
         req_b_valid_q <= req_b_valid_d;
         req_a_q       <= req_a_d;
         req_b_q       <= req_b_d;
         id_a_q        <= id_a_d;
         id_b_q        <= id_b_d;
         lat_err_q     <= lat_err_d;
      end
   end

   lookup_tag_pipe #(.LATENCY(LATENCY), .ID_W(ID_W)) u_tag_a (
      .clk     (clk),
      .rst     (rst),
      .in_v    (req_a_valid_q),
      .in_id   (id_a_q),
      .slot_v  (slot_a_v),
      .slot_id (slot_a_id),
      .any_v   (any_a)
   );

   lookup_tag_pipe #(.LATENCY(LATENCY), .ID_W(ID_W)) u_tag_b (
      .clk     (clk),
      .rst     (rst),
      .in_v    (req_b_valid_q),
      .in_id   (id_b_q),
      .slot_v  (slot_b_v),
      .slot_id (slot_b_id),
      .any_v   (any_b)
   );

   assign req_a_valid    = req_a_valid_q;
   assign req_a_type     = req_a_q.lk_type;
   assign req_a_host_idx = req_a_q.host_idx;
   assign req_a_src_sw   = req_a_q.src_sw;
   assign req_a_dst_sw   = req_a_q.dst_sw;
   assign req_b_valid    = req_b_valid_q;
   assign req_b_type     = req_b_q.lk_type;
   assign req_b_host_idx = req_b_q.host_idx;
   assign req_b_src_sw   = req_b_q.src_sw;
   assign req_b_dst_sw   = req_b_q.dst_sw;

   assign done_a_valid   = slot_a_v && resp_a_valid;
   assign done_a_id      = slot_a_id;
   assign done_b_valid   = slot_b_v && resp_b_valid;
   assign done_b_id      = slot_b_id;
   assign lat_err        = lat_err_q;
   assign busy           = any_a || any_b || req_a_valid_q || req_b_valid_q;

endmodule

// File: tb/tb_routing_lookup_arbiter.sv
module tb_routing_lookup_arbiter;
   import routing_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int LATENCY = 3;

   logic                          clk = 1'b0;
   logic                          rst;
   logic                          system_ready;
   logic [NUM_REQ-1:0]            cli_valid;
   logic [NUM_REQ-1:0]            cli_ready;
   logic [NUM_REQ-1:0]            cli_type;
   logic [NUM_REQ*HOST_IDX_W-1:0] cli_host_idx;
   logic [NUM_REQ*SW_ID_W-1:0]    cli_src_sw;
   logic [NUM_REQ*SW_ID_W-1:0]    cli_dst_sw;
   logic                          req_a_valid, req_a_type, req_b_valid, req_b_type;
   logic [HOST_IDX_W-1:0]         req_a_host_idx, req_b_host_idx;
   logic [SW_ID_W-1:0]            req_a_src_sw, req_a_dst_sw, req_b_src_sw, req_b_dst_sw;
   logic                          resp_a_valid, resp_b_valid;
   logic                          done_a_valid, done_b_valid;
   logic [ID_W-1:0]               done_a_id, done_b_id;
   logic                          lat_err, err_clr, busy;

   always #5 clk = ~clk;

   routing_lookup_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .LATENCY(LATENCY)) dut (
      .clk            (clk),
      .rst            (rst),
      .system_ready   (system_ready),
      .cli_valid      (cli_valid),
      .cli_ready      (cli_ready),
      .cli_type       (cli_type),
      .cli_host_idx   (cli_host_idx),
      .cli_src_sw     (cli_src_sw),
      .cli_dst_sw     (cli_dst_sw),
      .req_a_valid    (req_a_valid),
      .req_a_type     (req_a_type),
      .req_a_host_idx (req_a_host_idx),
      .req_a_src_sw   (req_a_src_sw),
      .req_a_dst_sw   (req_a_dst_sw),
      .req_b_valid    (req_b_valid),
      .req_b_type     (req_b_type),
      .req_b_host_idx (req_b_host_idx),
      .req_b_src_sw   (req_b_src_sw),
      .req_b_dst_sw   (req_b_dst_sw),
      .resp_a_valid   (resp_a_valid),
      .resp_b_valid   (resp_b_valid),
      .done_a_valid   (done_a_valid),
      .done_a_id      (done_a_id),
      .done_b_valid   (done_b_valid),
      .done_b_id      (done_b_id),
      .lat_err        (lat_err),
      .err_clr        (err_clr),
      .busy           (busy)
   );

   int checks   = 0;
   int failures = 0;

   // Per-client request fields (host_idx doubles as a client signature).
   logic                  f_type [NUM_REQ];
   logic [HOST_IDX_W-1:0] f_host [NUM_REQ];
   logic [SW_ID_W-1:0]    f_src  [NUM_REQ];
   logic [SW_ID_W-1:0]    f_dst  [NUM_REQ];

   // Routing-system model: mv = responses it will return, mt = lookups the
   // arbiter should still be tracking (cleared by reset).
   logic [LATENCY-1:0] mv_a = '0, mv_b = '0, mt_a = '0, mt_b = '0;
   int                 mid_a [LATENCY];
   int                 mid_b [LATENCY];
   logic               hold_a = 1'b0, inject_b = 1'b0;

   typedef struct {
      logic                  rdy;
      logic [NUM_REQ-1:0]    valid;
      logic [NUM_REQ-1:0]    exp_ready;
      logic                  exp_av;
      logic [HOST_IDX_W-1:0] exp_ah;
      logic                  exp_bv;
      logic [HOST_IDX_W-1:0] exp_bh;
   } vec_t;
   vec_t tbl [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic pack_fields();
      for (int i = 0; i < NUM_REQ; i++) begin
         cli_type[i]                           = f_type[i];
         cli_host_idx[i*HOST_IDX_W +: HOST_IDX_W] = f_host[i];
         cli_src_sw[i*SW_ID_W +: SW_ID_W]      = f_src[i];
         cli_dst_sw[i*SW_ID_W +: SW_ID_W]      = f_dst[i];
      end
   endtask

   function automatic int id_of(input logic [HOST_IDX_W-1:0] h);
      int r = -1;
      for (int i = 0; i < NUM_REQ; i++)
         if (r < 0 && f_host[i] == h) r = i;
      return r;
   endfunction

   task automatic drive_resp();
      resp_a_valid = mv_a[LATENCY-1] && !hold_a;
      resp_b_valid = mv_b[LATENCY-1] || inject_b;
   endtask

   task automatic tick();
      logic va, vb;
      int   ia, ib;
      va = req_a_valid;
      vb = req_b_valid;
      ia = id_of(req_a_host_idx);
      ib = id_of(req_b_host_idx);
      @(posedge clk);
      #1;
      mv_a = {mv_a[LATENCY-2:0], va};
      mv_b = {mv_b[LATENCY-2:0], vb};
      mt_a = {mt_a[LATENCY-2:0], va};
      mt_b = {mt_b[LATENCY-2:0], vb};
      for (int k = LATENCY - 1; k > 0; k--) begin
         mid_a[k] = mid_a[k-1];
         mid_b[k] = mid_b[k-1];
      end
      mid_a[0] = ia;
      mid_b[0] = ib;
      drive_resp();
   endtask

   task automatic check_done();
      logic ea, eb;
      ea = mt_a[LATENCY-1] && resp_a_valid && !rst;
      eb = mt_b[LATENCY-1] && resp_b_valid && !rst;
      check("done_a_valid", 32'(done_a_valid), 32'(ea));
      check("done_b_valid", 32'(done_b_valid), 32'(eb));
      if (ea) check("done_a_id", 32'(done_a_id), 32'(mid_a[LATENCY-1]));
      if (eb) check("done_b_id", 32'(done_b_id), 32'(mid_b[LATENCY-1]));
   endtask

   task automatic cyc();
      check_done();
      tick();
   endtask

   initial begin
      for (int i = 0; i < NUM_REQ; i++) begin
         f_type[i] = i[0];
         f_host[i] = HOST_IDX_W'(8 + i);
         f_src[i]  = SW_ID_W'(i);
         f_dst[i]  = SW_ID_W'(3 - i);
      end
      for (int k = 0; k < LATENCY; k++) begin
         mid_a[k] = 0;
         mid_b[k] = 0;
      end
      pack_fields();

      tbl[0]  = '{1'b1, 4'b0100, 4'b0100, 1'b0, 6'd0,  1'b0, 6'd0};
      tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, 6'd10, 1'b0, 6'd0};
      tbl[2]  = '{1'b1, 4'b1111, 4'b1001, 1'b0, 6'd10, 1'b0, 6'd0};
      tbl[3]  = '{1'b1, 4'b1111, 4'b0110, 1'b1, 6'd11, 1'b1, 6'd8};
      tbl[4]  = '{1'b1, 4'b1111, 4'b1001, 1'b1, 6'd9,  1'b1, 6'd10};
      tbl[5]  = '{1'b1, 4'b0101, 4'b0101, 1'b1, 6'd11, 1'b1, 6'd8};
      tbl[6]  = '{1'b1, 4'b0010, 4'b0010, 1'b1, 6'd10, 1'b1, 6'd8};
      tbl[7]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 6'd9,  1'b0, 6'd8};
      tbl[8]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 6'd9,  1'b0, 6'd8};
      tbl[9]  = '{1'b1, 4'b1000, 4'b1000, 1'b0, 6'd9,  1'b0, 6'd8};
      tbl[10] = '{1'b1, 4'b1111, 4'b0011, 1'b1, 6'd11, 1'b0, 6'd8};
      tbl[11] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 6'd8,  1'b1, 6'd9};
      tbl[12] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 6'd8,  1'b0, 6'd9};

      // Reset state, with requests pending and the system ready.
      rst = 1'b1; system_ready = 1'b1; cli_valid = 4'hF; err_clr = 1'b0;
      resp_a_valid = 1'b0; resp_b_valid = 1'b0;
      @(negedge clk);
      check("rst cli_ready", 32'(cli_ready), 32'd0);
      check("rst req_a_valid", 32'(req_a_valid), 32'd0);
      check("rst req_b_valid", 32'(req_b_valid), 32'd0);
      check("rst req_a_host", 32'(req_a_host_idx), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst lat_err", 32'(lat_err), 32'd0);
      cyc();
      rst = 1'b0;

      // Round-robin grant / issue vectors.
      for (int r = 0; r < 13; r++) begin
         system_ready = tbl[r].rdy;
         cli_valid    = tbl[r].valid;
         @(negedge clk);
         check($sformatf("tbl%0d cli_ready", r), 32'(cli_ready), 32'(tbl[r].exp_ready));
         check($sformatf("tbl%0d req_a_valid", r), 32'(req_a_valid), 32'(tbl[r].exp_av));
         check($sformatf("tbl%0d req_a_host", r), 32'(req_a_host_idx), 32'(tbl[r].exp_ah));
         check($sformatf("tbl%0d req_b_valid", r), 32'(req_b_valid), 32'(tbl[r].exp_bv));
         check($sformatf("tbl%0d req_b_host", r), 32'(req_b_host_idx), 32'(tbl[r].exp_bh));
         check($sformatf("tbl%0d lat_err", r), 32'(lat_err), 32'd0);
         cyc();
      end
      repeat (4) begin @(negedge clk); cyc(); end
      check("drain busy", 32'(busy), 32'd0);

      // Single request: client 2, host_idx 5.
      f_host[2] = 6'd5; pack_fields();
      cli_valid = 4'b0100;
      @(negedge clk);
      check("single cli_ready", 32'(cli_ready), 32'b0100);
      cyc();
      cli_valid = 4'b0000;
      @(negedge clk);
      check("single req_a_valid", 32'(req_a_valid), 32'd1);
      check("single req_a_host", 32'(req_a_host_idx), 32'd5);
      check("single req_b_valid", 32'(req_b_valid), 32'd0);
      check("single busy", 32'(busy), 32'd1);
      cyc();
      @(negedge clk); cyc();
      @(negedge clk); cyc();
      @(negedge clk);
      check("single done_a_valid", 32'(done_a_valid), 32'd1);
      check("single done_a_id", 32'(done_a_id), 32'd2);
      check("single lat_err", 32'(lat_err), 32'd0);
      cyc();
      @(negedge clk);
      check("single busy after", 32'(busy), 32'd0);
      check("single lat_err after", 32'(lat_err), 32'd0);
      cyc();

      // Dual-port: move pointer to 1, then client 1 host and client 3 path.
      f_type[1] = LK_HOST; f_host[1] = 6'd1;
      f_type[3] = LK_PATH; f_host[3] = 6'd7; f_src[3] = 4'd3; f_dst[3] = 4'd1;
      pack_fields();
      cli_valid = 4'b0001;
      @(negedge clk);
      check("dual pre cli_ready", 32'(cli_ready), 32'b0001);
      cyc();
      cli_valid = 4'b1010;
      @(negedge clk);
      check("dual cli_ready", 32'(cli_ready), 32'b1010);
      cyc();
      cli_valid = 4'b0000;
      @(negedge clk);
      check("dual req_a_valid", 32'(req_a_valid), 32'd1);
      check("dual req_a_type", 32'(req_a_type), 32'(LK_HOST));
      check("dual req_a_host", 32'(req_a_host_idx), 32'd1);
      check("dual req_b_valid", 32'(req_b_valid), 32'd1);
      check("dual req_b_type", 32'(req_b_type), 32'(LK_PATH));
      check("dual req_b_src", 32'(req_b_src_sw), 32'd3);
      check("dual req_b_dst", 32'(req_b_dst_sw), 32'd1);
      cyc();
      @(negedge clk); cyc();
      @(negedge clk); cyc();
      @(negedge clk);
      check("dual done_a_valid", 32'(done_a_valid), 32'd1);
      check("dual done_a_id", 32'(done_a_id), 32'd1);
      check("dual done_b_valid", 32'(done_b_valid), 32'd1);
      check("dual done_b_id", 32'(done_b_id), 32'd3);
      cyc();
      @(negedge clk); cyc();

      // Latency error: response for a port-A lookup is withheld.
      hold_a = 1'b1;
      cli_valid = 4'b0001;
      @(negedge clk);
      check("lat cli_ready", 32'(cli_ready), 32'b0001);
      cyc();
      cli_valid = 4'b0000;
      repeat (3) begin @(negedge clk); cyc(); end
      @(negedge clk);
      check("lat slot done_a", 32'(done_a_valid), 32'd0);
      check("lat slot lat_err", 32'(lat_err), 32'd0);
      cyc();
      hold_a = 1'b0; drive_resp();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("lat sticky%0d", i), 32'(lat_err), 32'd1);
         cyc();
      end
      err_clr = 1'b1;
      @(negedge clk); cyc();
      err_clr = 1'b0;
      @(negedge clk);
      check("lat cleared", 32'(lat_err), 32'd0);
      cyc();
      inject_b = 1'b1; drive_resp();
      @(negedge clk);
      check("unsolicited done_b", 32'(done_b_valid), 32'd0);
      cyc();
      inject_b = 1'b0; drive_resp();
      @(negedge clk);
      check("unsolicited lat_err", 32'(lat_err), 32'd1);
      cyc();
      err_clr = 1'b1; inject_b = 1'b1; drive_resp();
      @(negedge clk); cyc();
      err_clr = 1'b0; inject_b = 1'b0; drive_resp();
      @(negedge clk);
      check("set beats clear", 32'(lat_err), 32'd1);
      cyc();

      // Reset with three lookups in flight (lat_err still set).
      cli_valid = 4'b1111;
      @(negedge clk);
      check("mid H1 cli_ready", 32'(cli_ready), 32'b0110);
      check("mid pre lat_err", 32'(lat_err), 32'd1);
      cyc();
      cli_valid = 4'b0001;
      @(negedge clk);
      check("mid H2 cli_ready", 32'(cli_ready), 32'b0001);
      cyc();
      check("mid in-flight busy", 32'(busy), 32'd1);
      rst = 1'b1; cli_valid = 4'b1111;
      mt_a = '0; mt_b = '0;
      @(negedge clk);
      check("mid rst busy", 32'(busy), 32'd0);
      check("mid rst lat_err", 32'(lat_err), 32'd0);
      check("mid rst req_a_valid", 32'(req_a_valid), 32'd0);
      check("mid rst cli_ready", 32'(cli_ready), 32'd0);
      check("mid rst done_a", 32'(done_a_valid), 32'd0);
      cyc();
      rst = 1'b0; cli_valid = 4'b0000;
      @(negedge clk); cyc();
      @(negedge clk);
      check("stale resp_a seen", 32'(resp_a_valid), 32'd1);
      check("stale done_a", 32'(done_a_valid), 32'd0);
      check("stale done_b", 32'(done_b_valid), 32'd0);
      cyc();
      @(negedge clk);
      check("stale lat_err", 32'(lat_err), 32'd1);
      cyc();
      err_clr = 1'b1;
      @(negedge clk); cyc();
      err_clr = 1'b0;

      // Not ready for 10 cycles, then contention from rr_ptr=0.
      system_ready = 1'b0; cli_valid = 4'hF;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("notrdy%0d cli_ready", i), 32'(cli_ready), 32'd0);
         check($sformatf("notrdy%0d req_a_valid", i), 32'(req_a_valid), 32'd0);
         check($sformatf("notrdy%0d req_b_valid", i), 32'(req_b_valid), 32'd0);
         cyc();
      end
      system_ready = 1'b1;
      @(negedge clk);
      check("cont0 cli_ready", 32'(cli_ready), 32'b0011);
      cyc();
      @(negedge clk);
      check("cont1 cli_ready", 32'(cli_ready), 32'b1100);
      check("cont1 req_a_host", 32'(req_a_host_idx), 32'd8);
      check("cont1 req_b_host", 32'(req_b_host_idx), 32'd1);
      cyc();
      @(negedge clk);
      check("cont2 cli_ready", 32'(cli_ready), 32'b0011);
      check("cont2 req_a_host", 32'(req_a_host_idx), 32'd5);
      check("cont2 req_b_host", 32'(req_b_host_idx), 32'd7);
      cyc();
      cli_valid = 4'b0000;
      repeat (5) begin @(negedge clk); cyc(); end
      @(negedge clk);
      check("final lat_err", 32'(lat_err), 32'd0);
      check("final busy", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
